rr_mux_n: RTL
=============

# rr_mux_n

Parametrised, registered N-channel multiplexer with valid/ready handshaking on every input and on the output. It is the sequential successor to the plain gate-level 4:1 select. It arbitrates among CHANNELS input streams in one of three modes: round-robin, fixed priority or static select. The winning beat is captured into a single output register that sustains full throughput under back-pressure. It sits between several producer blocks and one shared consumer, for example a shared bus or a serialiser.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), width of channel index
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel beat valid
- in_ready  output  CHANNELS  per-channel accept; a beat transfers when in_valid[i] & in_ready[i]
- mode  input  2  00 round-robin, 01 fixed priority (lowest index wins), 10 static select, 11 treated as 00
- sel  input  SEL_W  channel index used in static mode
- out_data  output  WIDTH  registered selected data
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accept; the beat leaves when out_valid & out_ready

## Operation
- State: output register (out_data, out_sel, out_valid) and round-robin pointer ptr (SEL_W bits).
- Load enable: load = ~out_valid | out_ready. When load is 0, all in_ready are 0.
- Grant (combinational, at most one bit set):
  - Round-robin: the first i with in_valid[i], searching ptr, ptr+1, … with wrap modulo CHANNELS.
  - Fixed priority: the lowest i with in_valid[i].
  - Static: grant[sel] = in_valid[sel]. If sel ≥ CHANNELS, there is no grant.
- in_ready[i] = grant[i] & load. in_ready does not depend on in_valid[i] except through the grant.
- On a transfer from channel g: out_data ← channel g data, out_sel ← g, out_valid ← 1.
- If load is 1 and there is no grant, out_valid ← 0. out_data and out_sel hold their values.
- Pointer:
  - After a transfer in round-robin mode, ptr ← (g+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
  - In the other modes, ptr is unchanged.
  - With no transfer, ptr is unchanged.
- Mode or sel changes take effect for the grant in the same cycle. A beat already held in the output register is unaffected.
- A non-granted valid input holds its beat; it is never dropped or duplicated.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=all 0 while rst is high.
- Reset asserted mid-transfer discards the held beat immediately (asynchronous). The first grant after release uses ptr=0.
- Latency: an input handshake in cycle n gives out_valid=1 with that data in cycle n+1.
- Throughput: one beat per cycle when out_ready is held at 1. Output pop and input push in the same cycle are allowed.
- Back-pressure: with out_valid=1 and out_ready=0, the output holds stable and all in_ready are 0.
- Round-robin fairness: with all channels continuously valid, the grants cycle 0,1,…,CHANNELS-1,0. No channel waits more than CHANNELS-1 transfers.

## Test plan
- Reset: assert rst asynchronously between edges with out_valid=1 → out_valid, out_data, out_sel drop to 0 immediately; after release with in_valid=4'b1111, the first out_sel is 0.
- Round-robin with all valid, out_ready=1, channel i data = 8'hA0+i → out_data sequence A0,A1,A2,A3,A0 on consecutive cycles, each one cycle after its handshake.
- Sparse round-robin with in_valid=4'b1010, ptr=0 → grants 1,3,1,3; then set in_valid=4'b0001 → grant 0 (wrap search).
- Fixed priority with in_valid=4'b1110 held → out_sel stays 1 each cycle; channels 2 and 3 are never granted while channel 1 stays valid.
- Static mode with sel=2 and in_valid=4'b1011 → no transfer and out_valid=0; raise in_valid[2] → out_data = channel 2 data the next cycle.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 → out_data stable and in_ready=0; raise out_ready → the held beat pops and a new beat loads in the same cycle, with no loss and no duplication.

Source files
------------

// File: rtl/rr_mux_n_if.sv
// -----------------------------------------------------------------------------
// rr_mux_n_if
// Bundle of the handshake and data signals around rr_mux_n.
//   in_data   : CHANNELS*WIDTH, channel i in bits [i*WIDTH +: WIDTH]
//   in_valid  : per-channel beat valid
//   in_ready  : per-channel accept from the multiplexer
//   mode      : 00 round-robin, 01 fixed priority, 10 static select, 11 = 00
//   sel       : channel index used in static mode
//   out_data  : registered selected data
//   out_sel   : index of the channel that supplied out_data
//   out_valid : output register holds a beat
//   out_ready : consumer accept
// Modports:
//   master : producer/consumer side (drives inputs, observes outputs)
//   slave  : the multiplexer itself
// -----------------------------------------------------------------------------
interface rr_mux_n_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [1:0]                mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_mux_n.sv
// -----------------------------------------------------------------------------
// rr_mux_n
// Registered N-channel multiplexer with valid/ready on every input and on the
// output. Each cycle one input channel is granted (round-robin, fixed priority
// or static select) and its beat is captured into a single output register.
// The register reloads whenever it is empty or being popped, so one beat per
// cycle flows when out_ready stays high.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : rr_mux_n_if.slave (inputs, per-channel ready, registered output)
// -----------------------------------------------------------------------------
module rr_mux_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic      clk,
    input  logic      rst,
    rr_mux_n_if.slave bus
);

    localparam logic [1:0]       MODE_FIXED  = 2'b01;
    localparam logic [1:0]       MODE_STATIC = 2'b10;
    localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(CHANNELS - 1);
    // Channel count one bit wider than an index, so range checks on sel are
    // meaningful even when CHANNELS is a power of two.
    localparam logic [SEL_W:0]   CHANNELS_X  = (SEL_W + 1)'(CHANNELS);

    // (a + b) mod CHANNELS for a, b already below CHANNELS.
    function automatic logic [SEL_W-1:0] wrap_add(
        input logic [SEL_W-1:0] a,
        input logic [SEL_W-1:0] b
    );
        logic [SEL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sum = (sum >= CHANNELS_X) ? (sum - CHANNELS_X) : sum;
        return sum[SEL_W-1:0];
    endfunction

    // Rotate the valid vector so that bit k is channel (start + k) mod CHANNELS.
    function automatic logic [CHANNELS-1:0] rotate_from(
        input logic [CHANNELS-1:0] vec,
        input logic [SEL_W-1:0]    start
    );
        logic [CHANNELS-1:0] rot;
        rot = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            rot[k] = vec[wrap_add(start, SEL_W'(k))];
        end
        return rot;
    endfunction

    // Lowest set bit: returns {found, index}.
    function automatic logic [SEL_W:0] first_set(
        input logic [CHANNELS-1:0] vec
    );
        logic [SEL_W:0] res;
        res = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            res = vec[i] ? {1'b1, SEL_W'(i)} : res;
        end
        return res;
    endfunction

    logic [WIDTH-1:0]    out_data_r;
    logic [SEL_W-1:0]    out_sel_r;
    logic                out_valid_r;
    logic [SEL_W-1:0]    ptr_r;

    logic                load_s;
    logic                rr_mode_s;
    logic [SEL_W:0]      rr_search_s;
    logic [SEL_W:0]      fixed_search_s;
    logic                grant_any_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic [CHANNELS-1:0] grant_s;
    logic [WIDTH-1:0]    grant_data_s;
    logic [SEL_W-1:0]    ptr_next_s;

    // The output register can accept a new beat when empty or being drained.
    assign load_s    = ~out_valid_r | bus.out_ready;
    // Mode 11 falls back to round-robin along with 00.
    assign rr_mode_s = (bus.mode != MODE_FIXED) && (bus.mode != MODE_STATIC);

    // Candidate searches for the two search-based arbitration modes.
    assign rr_search_s    = first_set(rotate_from(bus.in_valid, ptr_r));
    assign fixed_search_s = first_set(bus.in_valid);

    // Grant selection: one winning channel index plus a found flag.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        case (bus.mode)
            MODE_FIXED: begin
                grant_any_s = fixed_search_s[SEL_W];
                grant_idx_s = fixed_search_s[SEL_W-1:0];
            end
            MODE_STATIC: begin
                // An out-of-range sel never grants anything.
                if ({1'b0, bus.sel} < CHANNELS_X) begin
                    grant_any_s = bus.in_valid[bus.sel];
                    grant_idx_s = bus.sel;
                end else begin
                    grant_any_s = 1'b0;
                    grant_idx_s = '0;
                end
            end
            default: begin
                // The rotated search returns an offset from the pointer.
                grant_any_s = rr_search_s[SEL_W];
                grant_idx_s = wrap_add(ptr_r, rr_search_s[SEL_W-1:0]);
            end
        endcase
    end

    // One-hot grant vector and AND-OR data selection of the winning channel.
    always_comb begin
        grant_s      = '0;
        grant_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_s[i]   = grant_any_s && (grant_idx_s == SEL_W'(i));
            grant_data_s = grant_data_s
                         | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

    // Pointer moves just past the winner, wrapping from the last channel to 0.
    assign ptr_next_s = (grant_idx_s == LAST_CH) ? '0 : (grant_idx_s + SEL_W'(1));

    // Ready is held low during reset so nothing transfers into a register
    // that is being cleared.
    assign bus.in_ready = grant_s & {CHANNELS{load_s & ~rst}};

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= '0;
            out_sel_r   <= '0;
            out_valid_r <= 1'b0;
            ptr_r       <= '0;
        end else if (load_s && grant_any_s) begin
            out_data_r  <= grant_data_s;
            out_sel_r   <= grant_idx_s;
            out_valid_r <= 1'b1;
            ptr_r       <= rr_mode_s ? ptr_next_s : ptr_r;
        end else if (load_s) begin
            // Drained with nothing to replace it; data and index keep their value.
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;
    assign bus.out_valid = out_valid_r;

endmodule
